// File: rtl/io_timer_irq_if.sv
// j1 IO bus bundle: the CPU side drives strobes, address and write data,
// and the responder returns registered read data.
`timescale 1ns/1ps
interface io_timer_irq_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (output io_rd, io_wr, io_addr, io_dout, input io_din);
  modport slave  (input io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/io_timer_irq.sv
// IO-mapped timer/interrupt responder: prescaled 16-bit down counter, external
// interrupt edge detector, free-running tick counter and pending/enable logic.
`timescale 1ns/1ps
module io_timer_irq #(
  parameter logic [15:0] BASE         = 16'h0040,
  parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
  input  logic            clk,
  input  logic            resetq,
  io_timer_irq_if.slave   bus,
  input  logic            ext_irq,
  output logic            interrupt_request,
  output logic            timer_tick
);

  logic [3:0]  r_ctrl;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [7:0]  r_prescale;
  logic [7:0]  r_ps;
  logic [1:0]  r_status;
  logic [15:0] r_ticks;
  logic        r_sync1, r_sync2, r_sync3;
  logic [15:0] r_din;
  logic        r_irq;
  logic        r_tick;

  logic        w_hit;
  logic [2:0]  w_idx;
  logic        w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_prescale, w_wr_status;
  logic        w_tick;
  logic        w_expire;
  logic        w_ext_edge;
  logic [1:0]  w_status_clr;
  logic [15:0] w_rd_data;
  logic        w_unused;

  assign w_hit    = (bus.io_addr[15:4] == BASE[15:4]);
  assign w_idx    = bus.io_addr[3:1];
  assign w_unused = bus.io_addr[0];

  assign w_wr_ctrl     = bus.io_wr & w_hit & (w_idx == 3'd0);
  assign w_wr_reload   = bus.io_wr & w_hit & (w_idx == 3'd1);
  assign w_wr_count    = bus.io_wr & w_hit & (w_idx == 3'd2);
  assign w_wr_prescale = bus.io_wr & w_hit & (w_idx == 3'd3);
  assign w_wr_status   = bus.io_wr & w_hit & (w_idx == 3'd4);

  // A COUNT write in the tick cycle overrides the decrement and suppresses expiry.
  assign w_tick       = r_ctrl[0] & (r_ps == 8'd0);
  assign w_expire     = w_tick & (r_count == 16'd0) & ~w_wr_count;
  assign w_ext_edge   = r_sync2 & ~r_sync3;
  assign w_status_clr = w_wr_status ? bus.io_dout[1:0] : 2'b00;

  always_comb begin
    // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
    w_rd_data = '0;
    case (w_idx)
      3'd0:    w_rd_data = {12'b0, r_ctrl};
      3'd1:    w_rd_data = r_reload;
      3'd2:    w_rd_data = r_count;
      3'd3:    w_rd_data = {8'b0, r_prescale};
      3'd4:    w_rd_data = {14'b0, r_status};
      3'd5:    w_rd_data = r_ticks;
      default: w_rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_ctrl     <= '0;
      r_reload   <= '0;
      r_prescale <= PRESCALE_RST;
      r_count    <= '0;
    end else begin
      if (w_wr_ctrl)
        r_ctrl <= bus.io_dout[3:0];
      else if (w_expire && !r_ctrl[1])
        r_ctrl[0] <= 1'b0;

      if (w_wr_reload)   r_reload   <= bus.io_dout;
      if (w_wr_prescale) r_prescale <= bus.io_dout[7:0];

      if (w_wr_count)
        r_count <= bus.io_dout;
      else if (w_tick) begin
        if (r_count != 16'd0) r_count <= r_count - 16'd1;
        else if (r_ctrl[1])   r_count <= r_reload;
      end
    end
  end

  // Prescaler: any CTRL/PRESCALE write restarts the period from the (new) PRESCALE.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      r_ps <= '0;
    else if (w_wr_prescale)
      r_ps <= bus.io_dout[7:0];
    else if (w_wr_ctrl || !r_ctrl[0] || (r_ps == 8'd0))
      r_ps <= r_prescale;
    else
      r_ps <= r_ps - 8'd1;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_status <= '0;
      r_ticks  <= '0;
      r_irq    <= 1'b0;
      r_tick   <= 1'b0;
      r_din    <= '0;
    end else begin
      r_sync1  <= ext_irq;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      // Set beats a simultaneous write-1-to-clear.
      r_status <= (r_status & ~w_status_clr) | {w_ext_edge, w_expire};
      r_ticks  <= r_ticks + 16'd1;
      r_irq    <= |(r_status & {r_ctrl[3], r_ctrl[2]});
      r_tick   <= w_tick;
      if (bus.io_rd)
        r_din <= w_hit ? w_rd_data : 16'h0000;
    end
  end

  assign bus.io_din        = r_din;
  assign interrupt_request = r_irq;
  assign timer_tick        = r_tick;

endmodule

// File: tb/tb_io_timer_irq.sv
// Self-checking bench for io_timer_irq: directed table, corner-case sequences
// and randomized bus traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_io_timer_irq;

  logic clk = 1'b0;
  logic resetq = 1'b0;
  logic ext_irq = 1'b0;
  logic interrupt_request;
  logic timer_tick;

  io_timer_irq_if bus ();

  io_timer_irq #(.BASE(16'h0040), .PRESCALE_RST(8'd0)) dut (
    .clk               (clk),
    .resetq            (resetq),
    .bus               (bus.slave),
    .ext_irq           (ext_irq),
    .interrupt_request (interrupt_request),
    .timer_tick        (timer_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int since_rst = 0;
  bit ext_lvl = 1'b0;

  // Behavioural model state
  logic [3:0]  m_ctrl;
  logic [15:0] m_reload, m_count, m_ticks, m_din;
  logic [7:0]  m_prescale, m_ps;
  logic [1:0]  m_status;
  logic        m_irq, m_tick;
  bit          m_ext[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] dout;
    bit          chk;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = '0; m_reload = '0; m_count = '0; m_ticks = '0; m_din = '0;
    m_prescale = 8'd0; m_ps = '0; m_status = '0; m_irq = 1'b0; m_tick = 1'b0;
    m_ext = '{1'b0, 1'b0, 1'b0};
    since_rst = 0;
  endfunction

  function automatic void model_step(input bit rd, input bit wr, input logic [15:0] addr,
                                     input logic [15:0] dout, input bit ext);
    bit          hit      = (addr[15:4] == 12'h004);
    int          idx      = int'(addr[3:1]);
    bit          wr_hit   = wr && hit;
    bit          tick     = m_ctrl[0] && (m_ps == 8'd0);
    bit          ext_rise = m_ext[1] && !m_ext[2];
    bit          cnt_wr   = wr_hit && (idx == 2);
    bit          expire   = tick && (m_count == 16'd0) && !cnt_wr;
    logic [15:0] rv       = 16'h0000;
    logic [3:0]  n_ctrl   = m_ctrl;
    logic [15:0] n_count  = m_count;
    logic [7:0]  n_ps;
    logic [1:0]  n_status = m_status;

    case (idx)
      0: rv = {12'b0, m_ctrl};
      1: rv = m_reload;
      2: rv = m_count;
      3: rv = {8'b0, m_prescale};
      4: rv = {14'b0, m_status};
      5: rv = m_ticks;
      default: rv = 16'h0000;
    endcase

    if (expire && !m_ctrl[1]) n_ctrl[0] = 1'b0;
    if (wr_hit && idx == 0) n_ctrl = dout[3:0];

    if (cnt_wr) n_count = dout;
    else if (tick) n_count = (m_count != 0) ? m_count - 16'd1 : (m_ctrl[1] ? m_reload : 16'd0);

    if (wr_hit && idx == 3)               n_ps = dout[7:0];
    else if ((wr_hit && idx == 0) || !m_ctrl[0] || tick) n_ps = m_prescale;
    else                                  n_ps = m_ps - 8'd1;

    if (wr_hit && idx == 4) n_status = n_status & ~dout[1:0];
    if (expire)   n_status[0] = 1'b1;
    if (ext_rise) n_status[1] = 1'b1;

    m_irq = (m_status[0] && m_ctrl[2]) || (m_status[1] && m_ctrl[3]);
    m_tick = tick;
    if (rd) m_din = hit ? rv : 16'h0000;
    if (wr_hit && idx == 1) m_reload = dout;
    if (wr_hit && idx == 3) m_prescale = dout[7:0];
    m_ctrl = n_ctrl;
    m_count = n_count;
    m_ps = n_ps;
    m_status = n_status;
    m_ticks = m_ticks + 16'd1;
    m_ext.push_front(ext);
    void'(m_ext.pop_back());
  endfunction

  task automatic step(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] dout);
    bus.io_rd = rd; bus.io_wr = wr; bus.io_addr = addr; bus.io_dout = dout; ext_irq = ext_lvl;
    model_step(rd, wr, addr, dout, ext_lvl);
    @(posedge clk);
    since_rst++;
    @(negedge clk);
    check("io_din", bus.io_din, m_din);
    check("interrupt_request", {15'b0, interrupt_request}, {15'b0, m_irq});
    check("timer_tick", {15'b0, timer_tick}, {15'b0, m_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_reg(input int idx, input logic [15:0] d);
    step(1'b0, 1'b1, 16'h0040 + 16'(idx * 2), d);
  endtask

  task automatic rd_reg(input int idx);
    step(1'b1, 1'b0, 16'h0040 + 16'(idx * 2), 16'h0000);
  endtask

  function automatic void add_vec(input bit rd, input bit wr, input logic [15:0] addr,
                                  input logic [15:0] dout, input bit chk, input logic [15:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.dout = dout; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_k[$];
    int irq_k;
    logic [15:0] exp_cnt;
    logic [15:0] addr;
    logic [15:0] dout;
    int op;

    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_dout = '0;
    model_reset();
    #12;
    check("rst io_din", bus.io_din, 16'h0000);
    check("rst irq", {15'b0, interrupt_request}, 16'h0000);
    check("rst tick", {15'b0, timer_tick}, 16'h0000);
    #11 resetq = 1'b1;

    // Directed register table (timer stopped throughout)
    add_vec(1, 0, 16'h0040, 16'h0000, 1, 16'h0000);
    add_vec(1, 0, 16'h0042, 16'h0000, 1, 16'h0000);
    add_vec(1, 0, 16'h0044, 16'h0000, 1, 16'h0000);
    add_vec(1, 0, 16'h0046, 16'h0000, 1, 16'h0000);
    add_vec(1, 0, 16'h0048, 16'h0000, 1, 16'h0000);
    add_vec(1, 0, 16'h004C, 16'h0000, 1, 16'h0000);
    add_vec(0, 1, 16'h0042, 16'hBEEF, 0, 16'h0000);
    add_vec(1, 0, 16'h0042, 16'h0000, 1, 16'hBEEF);
    add_vec(0, 1, 16'h0046, 16'h01FF, 0, 16'h0000);
    add_vec(1, 0, 16'h0046, 16'h0000, 1, 16'h00FF);
    add_vec(0, 1, 16'h0040, 16'h00F2, 0, 16'h0000);
    add_vec(1, 0, 16'h0040, 16'h0000, 1, 16'h0002);
    add_vec(0, 1, 16'h004E, 16'h5555, 0, 16'h0000);
    add_vec(1, 0, 16'h004E, 16'h0000, 1, 16'h0000);
    add_vec(0, 1, 16'h0044, 16'h0ABC, 0, 16'h0000);
    add_vec(1, 0, 16'h0044, 16'h0000, 1, 16'h0ABC);
    add_vec(0, 1, 16'h0082, 16'h1111, 0, 16'h0000);
    add_vec(1, 0, 16'h0042, 16'h0000, 1, 16'hBEEF);
    add_vec(1, 1, 16'h0042, 16'h7777, 1, 16'hBEEF);
    add_vec(1, 0, 16'h0042, 16'h0000, 1, 16'h7777);
    add_vec(1, 0, 16'h0080, 16'h0000, 1, 16'h0000);
    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dout);
      if (vecs[i].chk) check($sformatf("vec%0d", i), bus.io_din, vecs[i].exp);
    end
    exp_cnt = 16'(since_rst);
    rd_reg(5);
    check("ticks since reset", bus.io_din, exp_cnt);
    wr_reg(0, 16'h0000);

    // One-shot: PRESCALE=3, COUNT=2, run + timer irq enable
    wr_reg(3, 16'h0003);
    wr_reg(2, 16'h0002);
    wr_reg(0, 16'h0005);
    irq_k = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (timer_tick) tick_k.push_back(k);
      if (interrupt_request && irq_k == 0) irq_k = k;
    end
    check("oneshot tick count", 16'(tick_k.size()), 16'd3);
    if (tick_k.size() == 3) begin
      check("oneshot tick1", 16'(tick_k[0]), 16'd4);
      check("oneshot tick2", 16'(tick_k[1]), 16'd8);
      check("oneshot tick3", 16'(tick_k[2]), 16'd12);
    end
    check("oneshot irq cycle", 16'(irq_k), 16'd13);
    rd_reg(4);
    check("oneshot status", bus.io_din, 16'h0001);
    rd_reg(0);
    check("oneshot run cleared", bus.io_din, 16'h0004);
    wr_reg(4, 16'h0001);
    idle(1);
    check("oneshot irq cleared", {15'b0, interrupt_request}, 16'h0000);

    // Autoreload: PRESCALE=0, RELOAD=5, COUNT=0
    wr_reg(3, 16'h0000);
    wr_reg(1, 16'h0005);
    wr_reg(2, 16'h0000);
    wr_reg(0, 16'h0007);
    exp_cnt = 16'h0000;
    for (int i = 0; i < 14; i++) begin
      rd_reg(2);
      check($sformatf("reload count%0d", i), bus.io_din, exp_cnt);
      exp_cnt = (exp_cnt == 16'h0000) ? 16'h0005 : exp_cnt - 16'h0001;
    end
    rd_reg(0);
    check("reload run kept", bus.io_din, 16'h0007);
    wr_reg(0, 16'h0000);
    wr_reg(4, 16'h0003);

    // External interrupt edge and set-beats-clear
    wr_reg(0, 16'h0008);
    ext_lvl = 1'b0; idle(4);
    ext_lvl = 1'b1; idle(3);
    rd_reg(4);
    check("ext status", bus.io_din, 16'h0002);
    check("ext irq", {15'b0, interrupt_request}, 16'h0001);
    ext_lvl = 1'b0; idle(4);
    ext_lvl = 1'b1; idle(2);
    wr_reg(4, 16'h0002);
    rd_reg(4);
    check("ext set beats clear", bus.io_din, 16'h0002);
    wr_reg(4, 16'h0002);
    rd_reg(4);
    check("ext cleared", bus.io_din, 16'h0000);

    // Miss read, TICKS write ignored, COUNT write vs tick
    rd_reg(0);
    check("hit read", bus.io_din, 16'h0008);
    step(1'b1, 1'b0, 16'h0080, 16'h0000);
    check("miss read", bus.io_din, 16'h0000);
    wr_reg(5, 16'h0000);
    exp_cnt = 16'(since_rst);
    rd_reg(5);
    check("ticks write ignored", bus.io_din, exp_cnt);
    wr_reg(0, 16'h0000);
    wr_reg(3, 16'h0000);
    wr_reg(2, 16'd100);
    wr_reg(0, 16'h0001);
    idle(2);
    wr_reg(2, 16'h1234);
    rd_reg(2);
    check("count write wins", bus.io_din, 16'h1234);
    wr_reg(2, 16'h0000);
    wr_reg(2, 16'h0007);
    rd_reg(4);
    check("no expiry on count write", bus.io_din, 16'h0000);
    rd_reg(0);
    check("run kept on count write", bus.io_din, 16'h0001);

    // Reset while running with pending interrupts
    wr_reg(1, 16'h0003);
    wr_reg(2, 16'h0000);
    wr_reg(0, 16'h0007);
    ext_lvl = 1'b1; idle(5);
    rd_reg(0);
    check("pre-reset irq", {15'b0, interrupt_request}, 16'h0001);
    check("pre-reset din", bus.io_din, 16'h0007);
    #2 resetq = 1'b0;
    #1;
    check("async rst din", bus.io_din, 16'h0000);
    check("async rst irq", {15'b0, interrupt_request}, 16'h0000);
    check("async rst tick", {15'b0, timer_tick}, 16'h0000);
    model_reset();
    ext_lvl = 1'b0; ext_irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
    idle(6);
    rd_reg(4);
    check("no stale ext edge", bus.io_din, 16'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) ext_lvl = ~ext_lvl;
      op = int'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
        addr = 16'($urandom);
        if (addr[15:4] == 12'h004) addr[15] = 1'b1;
      end else begin
        addr = 16'h0040 | 16'($urandom_range(15));
      end
      dout = 16'($urandom);
      case (addr[3:1])
        3'd1, 3'd2: dout = 16'($urandom_range(7));
        3'd3:       dout = 16'($urandom_range(3));
        default:    ;
      endcase
      step(op[0], op[1], addr, dout);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
